conv_window_gen: RTL

Sliding-window generator for the convolution datapath. It accepts a raster-order pixel stream, one pixel per valid cycle, and buffers K-1 image rows in line buffers. For every K×K stride-1 window lying fully inside the frame, it emits the window as a flat K*K array with a single-cycle valid pulse. It sits directly upstream of the K*K-input MAC stage and drives that stage's image-operand array and input-valid.

---
 rtl/conv_window_gen.sv | 98 +++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a raster pixel stream.
// Keeps K-1 line buffers and a KxK window register; flags windows fully inside the frame.
module conv_window_gen #(
  parameter int WIDTH = 32,
  parameter int K     = 7,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_val,
  input  logic                    i_sof,
  input  logic signed [WIDTH-1:0] i_pix,
  output logic signed [WIDTH-1:0] o_Img [K*K-1:0],
  output logic                    o_val,
  output logic                    o_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NB = (K > 1) ? K - 1 : 1;
  localparam int KK = K * K;

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] R_MIN  = RW'(K - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_in_win;
  logic          w_at_end;

  logic signed [WIDTH-1:0] r_lb  [NB][IMG_W];
  logic signed [WIDTH-1:0] r_win [KK-1:0];

  // i_sof forces the current pixel to (0,0) regardless of counter state
  always_comb begin
    w_col     = i_sof ? '0 : r_col;
    w_row     = i_sof ? '0 : r_row;
    w_col_nxt = w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_col == C_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == R_LAST) ? '0 : w_row + 1'b1;
    end
    w_in_win  = (w_row >= R_MIN) && (w_col >= C_MIN);
    w_at_end  = (w_row == R_LAST) && (w_col == C_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      o_val  <= 1'b0;
      o_last <= 1'b0;
    end else begin
      o_val  <= i_val && w_in_win;
      o_last <= i_val && w_in_win && w_at_end;
      if (i_val) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KK; i++)
        r_win[i] <= '0;
    end else if (i_val) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          r_win[r*K+c] <= r_win[r*K+c+1];
      for (int r = 0; r < K - 1; r++)
        r_win[r*K+K-1] <= r_lb[K-2-r][w_col];
      r_win[KK-1] <= i_pix;
    end
  end

  // Line buffers are never cleared; the row counter masks stale rows
  if (K > 1) begin : g_lb
    always_ff @(posedge clk) begin
      if (!rst && i_val) begin
        for (int b = NB - 1; b > 0; b--)
          r_lb[b][w_col] <= r_lb[b-1][w_col];
        r_lb[0][w_col] <= i_pix;
      end
    end
  end

  assign o_Img = r_win;

endmodule
